// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick/slot scheduler.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StShot = 2'd2
  } sched_state_e;

  // Default divider width; the divisor resets to all-ones of this width.
  localparam int unsigned DefaultDivW = 13;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescale counter with terminal-count detect against a programmable divisor.
module tick_prescaler #(
  parameter int unsigned DIV_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_reg,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == div_reg);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_slot_scheduler.sv
// Start/stop/one-shot prescaler controller that shares the tick period round-robin
// between N_SLOTS consumers.
module tick_slot_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned DIV_W   = DefaultDivW,
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned SLOT_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic               div_load,
  input  logic [DIV_W-1:0]   div_value,
  output logic               tick,
  output logic [SLOT_W-1:0]  slot,
  output logic [N_SLOTS-1:0] slot_en,
  output logic               busy,
  output logic               done
);

  sched_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic              slot_last;

  assign busy      = (state_q != StIdle);
  assign slot      = slot_q;
  assign slot_last = (slot_q == SLOT_W'(N_SLOTS - 1));

  tick_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (stop),
    .en     (busy),
    .div_reg(div_q),
    .tc     (tick)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = oneshot ? StShot : StRun;
      end
      StRun: begin
        if (stop) state_d = StIdle;
      end
      StShot: begin
        if (stop) begin
          state_d = StIdle;
        end else if (tick && slot_last) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    if (busy && stop) begin
      slot_d = '0;
    end else if (tick) begin
      slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // While busy a new divisor is staged so the period in progress is never cut short.
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (!busy) begin
      pend_d = 1'b0;
      if (div_load) begin
        div_d = div_value;
      end else if (pend_q) begin
        div_d = pend_val_q;
      end
    end else begin
      if ((tick || stop) && pend_q) begin
        div_d  = pend_val_q;
        pend_d = 1'b0;
      end
      if (div_load) begin
        pend_val_d = div_value;
        pend_d     = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_en[i] = busy && (slot_q == SLOT_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      slot_q     <= '0;
      div_q      <= '1;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

endmodule

// File: tb/tb_tick_slot_scheduler.sv
// Scoreboard bench: a reference model queues the expected outputs for every cycle;
// a monitor on the falling edge compares them with the DUT.
module tb_tick_slot_scheduler;

  localparam int DivW   = 13;
  localparam int NSlots = 4;

  logic            clk = 1'b0;
  logic            reset, start, stop, oneshot, div_load;
  logic [DivW-1:0] div_value;
  logic            tick, busy, done;
  logic [1:0]      slot;
  logic [3:0]      slot_en;

  always #5 clk = ~clk;

  tick_slot_scheduler #(
    .DIV_W  (DivW),
    .N_SLOTS(NSlots),
    .SLOT_W (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .oneshot  (oneshot),
    .div_load (div_load),
    .div_value(div_value),
    .tick     (tick),
    .slot     (slot),
    .slot_en  (slot_en),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    bit         chk;
    logic       tick;
    logic       busy;
    logic       done;
    logic [1:0] slot;
    logic [3:0] slot_en;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: a run is a sequence of periods of (div+1) cycles, each owned by
  // one slot; "elapsed" counts cycles already spent in the current period.
  bit m_run, m_shot, m_pend;
  int m_elapsed, m_slot, m_div, m_pend_val;

  task automatic model_reset();
    m_run = 0; m_shot = 0; m_pend = 0;
    m_elapsed = 0; m_slot = 0; m_div = (1 << DivW) - 1; m_pend_val = 0;
  endtask

  task automatic step(input bit a_rst, input bit a_start, input bit a_stop,
                      input bit a_os, input bit a_ld, input int a_val);
    exp_t e;
    bit   end_of_period;
    int   v;
    v         = a_val % (1 << DivW);
    reset     = a_rst;
    start     = a_start;
    stop      = a_stop;
    oneshot   = a_os;
    div_load  = a_ld;
    div_value = v[DivW-1:0];

    end_of_period = m_run && (m_elapsed == m_div);
    e.chk     = !a_rst;
    e.tick    = end_of_period;
    e.busy    = m_run;
    e.slot    = 2'(m_slot);
    e.slot_en = m_run ? 4'(1 << m_slot) : 4'b0;
    e.done    = m_run && m_shot && end_of_period && (m_slot == NSlots - 1) && !a_stop;
    exp_q.push_back(e);

    if (a_rst) begin
      model_reset();
    end else if (!m_run) begin
      if (a_ld) m_div = v;
      else if (m_pend) m_div = m_pend_val;
      m_pend = 0;
      if (a_start && !a_stop) begin
        m_run = 1; m_shot = a_os; m_elapsed = 0; m_slot = 0;
      end
    end else begin
      if ((end_of_period || a_stop) && m_pend) begin
        m_div  = m_pend_val;
        m_pend = 0;
      end
      if (a_ld) begin
        m_pend_val = v;
        m_pend     = 1;
      end
      if (a_stop) begin
        m_run = 0; m_elapsed = 0; m_slot = 0;
      end else if (end_of_period) begin
        m_elapsed = 0;
        if (m_slot == NSlots - 1) begin
          m_slot = 0;
          if (m_shot) m_run = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        vectors++;
        if (tick !== e.tick || busy !== e.busy || done !== e.done ||
            slot !== e.slot || slot_en !== e.slot_en) begin
          miscompares++;
          $display("FAIL outputs @%0t: got tick=%b busy=%b done=%b slot=%0d slot_en=%b, need tick=%b busy=%b done=%b slot=%0d slot_en=%b",
                   $time, tick, busy, done, slot, slot_en,
                   e.tick, e.busy, e.done, e.slot, e.slot_en);
        end
      end
    end
  end

  initial begin
    reset = 1; start = 0; stop = 0; oneshot = 0; div_load = 0; div_value = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // Continuous run at div=3
    step(0, 0, 0, 0, 1, 3);
    step(0, 1, 0, 0, 0, 0);
    idle(22);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // One-shot at div=1
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 0, 0);
    idle(12);

    // Mid-period reload: div 7 -> 2
    step(0, 0, 0, 0, 1, 7);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 2);
    idle(20);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // start&stop together in IDLE, then stop on the terminal count
    step(0, 1, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 3);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    idle(3);

    // One-shot stopped on its last terminal count: tick but no done
    step(0, 1, 0, 1, 0, 0);
    idle(15);
    step(0, 0, 1, 0, 0, 0);
    idle(3);

    // div=0 continuous, including a start while busy
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(6);
    step(0, 1, 0, 1, 0, 0);
    idle(4);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // Reset in SHOT at slot 2, then a run at the reset divisor
    step(0, 0, 0, 0, 1, 3);
    step(0, 1, 0, 1, 0, 0);
    idle(9);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 0, 0);
    idle(8200);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0,
           int'($urandom_range(0, 5)));
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
